// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous byte FIFO with push, pop, full, empty and count
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset since count gates every read
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, data_n, head;
  logic full, empty, pop, done, tx_n, tx_q;
  logic [$clog2(FIFO_DEPTH):0] count;
  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_valid),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign done = cnt == '0;
  assign pop = !empty && (state == IDLE || (state == STOP && done));
  assign bit_n = bit_idx + 3'(state == DATA && done);
  assign data_n = pop ? head : shreg;
  assign tx_ready = !full;
  assign busy = state != IDLE || count != '0;
  assign tx = tx_q;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: each bit lasts until the baud counter reaches zero
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = empty ? IDLE : START;
      START:  state_n = done ? DATA : START;
      DATA:   state_n = (done && bit_idx == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = done ? STOP : PARITY;
`endif
      STOP:   state_n = done ? (empty ? IDLE : START) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // line level for the next cycle, computed from next-state values so tx can be registered without extra latency
  always_comb begin
    tx_n = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    if (state_n == DATA) tx_n = data_n[bit_n];
`ifdef UART_TX_PARITY_EN
    if (state_n == PARITY) tx_n = ^data_n;
`endif
  end
  // baud counter, bit index, shift register and registered line output
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx_q <= 1'b1;
    end else begin
      cnt <= (state == IDLE || done) ? RELOAD : cnt - 1'b1;
      bit_idx <= bit_n;
      shreg <= data_n;
      tx_q <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F = (10 + PAR) * CPB;
  logic clk = 0, reset = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, tx, busy;
  int tests = 0, fails = 0, cyc = 0;
  logic hist_tx [4096];
  logic hist_busy [4096];
  logic hist_rdy [4096];
  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // cyc = number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;
  // hist_*[k] = outputs sampled mid-cycle after rising edge k
  always @(negedge clk)
    if (cyc < 4096) begin
      hist_tx[cyc] = tx;
      hist_busy[cyc] = busy;
      hist_rdy[cyc] = tx_ready;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic check_frame(input string tag, input int s, input logic [7:0] b);
    for (int i = 0; i < F; i++)
      chk($sformatf("%s_c%0d", tag, i), 32'(hist_tx[s+i]), 32'(exp_bit(b, i / CPB)));
  endtask
  task automatic push(input logic [7:0] b, output int acc);
    int n = 0;
    tx_data = b;
    tx_valid = 1;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", n, 0);
    acc = cyc + 1;
    @(negedge clk);
    tx_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int a, a2, a3, r, bad;
    int acc [6];
    #1 reset = 1;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(tx_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    r = cyc;
    push(8'h55, a);
    chk("first_accept", a, r + 1);
    wait_idle();
    chk("lat_tx", 32'(hist_tx[a]), 1);
    chk("lat_busy", 32'(hist_busy[a]), 1);
    check_frame("f55", a + 1, 8'h55);
    chk("busy_last", 32'(hist_busy[a+F]), 1);
    chk("busy_fall", 32'(hist_busy[a+F+1]), 0);
    chk("idle_tx", 32'(hist_tx[a+F+1]), 1);
    push(8'hA5, a);
    push(8'h3C, a2);
    push(8'hFF, a3);
    chk("b2b_acc2", a2, a + 1);
    chk("b2b_acc3", a3, a + 2);
    wait_idle();
    check_frame("fA5", a + 1, 8'hA5);
    check_frame("f3C", a + 1 + F, 8'h3C);
    check_frame("fFF", a + 1 + 2 * F, 8'hFF);
    chk("b2b_idle", 32'(hist_busy[a+3*F+1]), 0);
    for (int k = 0; k < 6; k++) push(8'(8'h10 + k), acc[k]);
    for (int k = 1; k < 5; k++) chk($sformatf("full_acc%0d", k), acc[k], acc[0] + k);
    chk("full_acc5", acc[5], acc[0] + F + 2);
    chk("full_rdy_low", 32'(hist_rdy[acc[0]+4]), 0);
    chk("full_rdy_prepop", 32'(hist_rdy[acc[0]+F]), 0);
    chk("full_rdy_postpop", 32'(hist_rdy[acc[0]+F+1]), 1);
    chk("full_rdy_refill", 32'(hist_rdy[acc[0]+F+2]), 0);
    wait_idle();
    for (int k = 0; k < 6; k++) check_frame($sformatf("ff%0d", k), acc[0] + 1 + k * F, 8'(8'h10 + k));
    push(8'h0F, a);
    push(8'h81, a2);
    push(8'h42, a3);
    while (cyc < a + 18) @(negedge clk);
    for (int i = 0; i < 17; i++)
      chk($sformatf("f0F_c%0d", i), 32'(hist_tx[a+1+i]), 32'(exp_bit(8'h0F, i / CPB)));
    chk("bit3_tx", 32'(tx), 1);
    chk("bit3_busy", 32'(busy), 1);
    chk("bit3_ready", 32'(tx_ready), 1);
    reset = 1;
    #1;
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(tx_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    r = cyc;
    repeat (100) @(negedge clk);
    bad = 0;
    for (int i = r + 1; i < r + 99; i++)
      if (hist_tx[i] !== 1'b1 || hist_busy[i] !== 1'b0) bad++;
    chk("abort_stays_idle", bad, 0);
    push(8'h07, a);
    wait_idle();
    check_frame("f07", a + 1, 8'h07);
    chk("f07_end", 32'(hist_busy[a+F+1]), 0);
    push(8'h03, a);
    wait_idle();
    check_frame("f03", a + 1, 8'h03);
    chk("f03_end", 32'(hist_busy[a+F+1]), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the transmit byte buffer; power of two, 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte offered for transmission.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the buffer can accept a byte this cycle.
REQ-008 The block SHALL have port tx, output, 1 bit: the serial line, idle high; it drives the datapath tx pin.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress or the buffer is non-empty.

Function
REQ-010 A byte SHALL be accepted on a rising clk edge where tx_valid=1 and tx_ready=1; tx_valid without tx_ready SHALL be ignored, and no data SHALL be lost or duplicated.
REQ-011 tx_ready SHALL be 1 exactly when the buffer holds fewer than FIFO_DEPTH bytes; it SHALL NOT depend combinationally on tx_valid.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (only when compiled in), and STOP.
REQ-013 IDLE SHALL drive tx=1 and go to START on the first edge where the buffer is non-empty, popping the head byte into the shift register on that same edge.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA SHALL drive the 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index that wraps 7->0, then go to PARITY or STOP.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-017 At the end of STOP, if the buffer is non-empty, the FSM SHALL go directly to START and pop (no idle gap); otherwise it SHALL go to IDLE.
REQ-018 Latency SHALL be one cycle: with the FSM in IDLE and the buffer empty, an acceptance at edge N SHALL give tx=0 from edge N+1.
REQ-019 Push and pop on the same edge SHALL both take effect, leaving the count unchanged; a pop at full SHALL NOT raise tx_ready until the following cycle.
REQ-020 Bit timing SHALL use a down-counter of width clog2(CLKS_PER_BIT), reloaded at each bit boundary, giving exact CLKS_PER_BIT cycles per bit with no cumulative drift.
REQ-021 The tx output SHALL come directly from a flip-flop (glitch-free).
REQ-022 busy SHALL be 0 only in IDLE with the buffer empty.

Reset
REQ-023 On reset=1, regardless of the clock: tx=1, busy=0, tx_ready=1, FSM=IDLE, buffer emptied, counters cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes; after release, no partial frame SHALL resume.
REQ-025 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, PARITY SHALL drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving 11-bit frames.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and frames SHALL be 10 bits.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state encoding and the constants DATA_BITS=8 and STOP_BITS=1, for reuse by the companion receiver.
REQ-029 The buffer SHALL be one sub-module, tx_fifo (synchronous FIFO with push, pop, full, empty and count); the FSM and baud counter SHALL remain in uart_tx.

Verification
REQ-030 CLKS_PER_BIT=4, send 0x55 -> tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; total 40 cycles; busy falls at cycle 40.
REQ-031 Push 0xA5, 0x3C, 0xFF back-to-back -> three contiguous frames with no idle cycles between the STOP of one frame and the START of the next; bytes appear in order.
REQ-032 FIFO_DEPTH=4, hold tx_valid=1 while the line is busy -> 5 bytes accepted (1 in the shifter, 4 buffered), then tx_ready=0 until the next pop; no loss.
REQ-033 Assert reset in DATA bit 3 of 0x0F with 2 bytes buffered -> tx=1 immediately; after release the line stays idle and busy=0.
REQ-034 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame length 44 cycles at CLKS_PER_BIT=4; send 0x03 -> parity bit 0.
